dict_decompressor: RTL and testbench
====================================

// Module: dict_decompressor
// PURPOSE
//  Dictionary decompression stage between the compressed instruction cache and the processor fetch port.
//  Accepts one compressed word (three dictionary indices) per handshake.
//  Looks up each index in its field dictionary and concatenates the results into the 32-bit instruction.
//  Dictionaries are loaded through a dedicated write port by the fill/compression path.
// PARAMETERS
//  FIELD1_IDX_SIZE  3   index width, field-1 dictionary (depth 2**3)
//  FIELD2_IDX_SIZE  8   index width, field-2 dictionary (depth 2**8)
//  FIELD3_IDX_SIZE  5   index width, field-3 dictionary (depth 2**5)
//  FIELD1_SIZE      7   field-1 value width -> instr[6:0]
//  FIELD2_SIZE      15  field-2 value width -> instr[21:7]
//  FIELD3_SIZE      10  field-3 value width -> instr[31:22]
//  (derived) CW = sum of IDX sizes = 16; FIELD sizes must sum to 32
// PORTS
//  clk          in   1   clock, rising edge
//  resetn       in   1   asynchronous reset, active low
//  in_valid     in   1   compressed word valid
//  in_ready     out  1   stage can accept
//  in_cw        in   CW  {idx3, idx2, idx1}; idx1 in LSBs
//  in_addr      in   32  fetch address sideband, passed through
//  out_valid    out  1   instruction valid
//  out_ready    in   1   consumer accepts
//  out_instr    out  32  {val3, val2, val1}
//  out_addr     out  32  sideband matching out_instr
//  dict_we      in   1   dictionary write strobe
//  dict_sel     in   2   1=field1, 2=field2, 3=field3; 0=no-op
//  dict_idx     in   8   entry index (max IDX width)
//  dict_wdata   in   15  entry value; low FIELDn_SIZE bits used
// BEHAVIOUR
//  Two registers: S1 (idx, addr, valid) and S2/output (instr, addr, valid). Lookup is combinational from S1 into S2.
//  Reset (async, resetn=0): s1_valid=0, out_valid=0, out_instr=0, out_addr=0; in_ready=1 after release.
//  Dictionary arrays are not reset; contents survive resetn.
//  adv2 = !out_valid | out_ready; in_ready = !s1_valid | adv2. Accept = in_valid & in_ready.
//  Latency: word accepted at edge N -> out_valid high after edge N+1. Throughput 1/cycle when out_ready=1.
//  Stall (out_ready=0 with out_valid=1): out_* held stable; S1 holds; in_ready falls once S1 is full. No drop, no duplicate, order preserved.
//  in_valid without in_ready: input ignored; upstream holds.
//  Dictionary write: takes effect at the clock edge. A lookup in the same cycle reads the pre-write value.
//  dict_idx bits above the selected field's IDX size must be 0; otherwise the write is dropped.
//  Writes are legal at any time, including mid-stream and during stalls.
//  Simultaneous accept, output handshake and dictionary write are all performed in the same cycle.
// CONFIGURATION
//  DECOMP_BYPASS_EN defined: adds ports in_raw (in, 1) and in_raw_instr (in, 32).
//    in_raw=1 with accept: in_raw_instr is carried through S1 and emitted unchanged, with the same latency and ordering.
//    Used for instructions escaped from the dictionary.
//  Not defined: no extra ports; every word is decoded.
// STRUCTURE
//  Package decomp_pkg holds:
//    default IDX/FIELD widths, CW, IW=32
//    field bit positions in instr and in cw
//    dict_sel encoding localparams (DSEL_NONE/F1/F2/F3)
//  Sub-module dict_bank #(IDX, VAL): register-array dictionary, sync write, async read. Instantiated three times.
// TESTING
//  1. Program f1[2]=7'h13, f2[8'h40]=15'h0A5A, f3[5]=10'h155.
//     Send in_cw=16'h2A02, in_addr=32'h100 -> out_instr=32'h55452D13, out_addr=32'h100, two edges after accept.
//  2. Four back-to-back words with out_ready=1 -> four outputs on consecutive cycles, order and addresses preserved.
//  3. out_ready=0 for 5 cycles under continuous in_valid -> two words accepted, then in_ready=0.
//     out_instr stays stable; all words emerge exactly once after release.
//  4. dict_we to f2[8'h40]=15'h1111 in the same cycle S1 holds idx2=8'h40 -> that output uses 15'h0A5A; the next lookup uses 15'h1111.
//  5. resetn=0 mid-stream -> out_valid=0 immediately (async); after release in_ready=1.
//     Replaying test 1's word yields 32'h55452D13 (dictionary retained).
//  6. DECOMP_BYPASS_EN: in_raw=1, in_raw_instr=32'hDEADBEEF between two compressed words -> output order cw, 32'hDEADBEEF, cw.

Source files
------------

// File: rtl/dict_decompressor_pkg.sv
// rtl/dict_decompressor_pkg.sv - shared widths, field positions and dict_sel encoding for dict_decompressor
package decomp_pkg;

  localparam int DEF_FIELD1_IDX_SIZE = 3;
  localparam int DEF_FIELD2_IDX_SIZE = 8;
  localparam int DEF_FIELD3_IDX_SIZE = 5;
  localparam int DEF_FIELD1_SIZE     = 7;
  localparam int DEF_FIELD2_SIZE     = 15;
  localparam int DEF_FIELD3_SIZE     = 10;

  localparam int CW = DEF_FIELD1_IDX_SIZE + DEF_FIELD2_IDX_SIZE + DEF_FIELD3_IDX_SIZE;
  localparam int IW = 32;

  localparam int DICT_IDX_W = 8;
  localparam int DICT_VAL_W = 15;

  localparam int F1_CW_LSB    = 0;
  localparam int F2_CW_LSB    = F1_CW_LSB + DEF_FIELD1_IDX_SIZE;
  localparam int F3_CW_LSB    = F2_CW_LSB + DEF_FIELD2_IDX_SIZE;
  localparam int F1_INSTR_LSB = 0;
  localparam int F2_INSTR_LSB = F1_INSTR_LSB + DEF_FIELD1_SIZE;
  localparam int F3_INSTR_LSB = F2_INSTR_LSB + DEF_FIELD2_SIZE;

  localparam logic [1:0] DSEL_NONE = 2'd0;
  localparam logic [1:0] DSEL_F1   = 2'd1;
  localparam logic [1:0] DSEL_F2   = 2'd2;
  localparam logic [1:0] DSEL_F3   = 2'd3;

  // A write index is legal only when no bit above the field's index width is set.
  function automatic logic idx_fits(input logic [DICT_IDX_W-1:0] idx, input int unsigned width);
    return (idx >> width) == '0;
  endfunction

endpackage

// File: rtl/dict_decompressor_if.sv
// rtl/dict_decompressor_if.sv - stream, sideband and dictionary-write signals; DECOMP_BYPASS_EN adds raw-instruction inputs
interface dict_decompressor_if
  import decomp_pkg::*;
  ;
  logic                  in_valid;
  logic                  in_ready;
  logic [CW-1:0]         in_cw;
  logic [IW-1:0]         in_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic [IW-1:0]         out_instr;
  logic [IW-1:0]         out_addr;
  logic                  dict_we;
  logic [1:0]            dict_sel;
  logic [DICT_IDX_W-1:0] dict_idx;
  logic [DICT_VAL_W-1:0] dict_wdata;
`ifdef DECOMP_BYPASS_EN
  logic                  in_raw;
  logic [IW-1:0]         in_raw_instr;

  modport master (
    output in_valid, in_cw, in_addr, in_raw, in_raw_instr, out_ready,
           dict_we, dict_sel, dict_idx, dict_wdata,
    input  in_ready, out_valid, out_instr, out_addr
  );
  modport slave (
    input  in_valid, in_cw, in_addr, in_raw, in_raw_instr, out_ready,
           dict_we, dict_sel, dict_idx, dict_wdata,
    output in_ready, out_valid, out_instr, out_addr
  );
`else
  modport master (
    output in_valid, in_cw, in_addr, out_ready,
           dict_we, dict_sel, dict_idx, dict_wdata,
    input  in_ready, out_valid, out_instr, out_addr
  );
  modport slave (
    input  in_valid, in_cw, in_addr, out_ready,
           dict_we, dict_sel, dict_idx, dict_wdata,
    output in_ready, out_valid, out_instr, out_addr
  );
`endif
endinterface

// File: rtl/dict_decompressor_dict_bank.sv
// rtl/dict_decompressor_dict_bank.sv - one field dictionary: register array, synchronous write, asynchronous read
module dict_bank #(
  parameter int IDX = 3,
  parameter int VAL = 7
) (
  input  logic           clk,
  input  logic           we,
  input  logic [IDX-1:0] waddr,
  input  logic [VAL-1:0] wdata,
  input  logic [IDX-1:0] raddr,
  output logic [VAL-1:0] rdata
);

  // Contents are deliberately not reset so a pipeline reset keeps the loaded dictionary.
  logic [VAL-1:0] mem_q [2**IDX];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dict_decompressor.sv
// rtl/dict_decompressor.sv - two-register dictionary decompression stage; DECOMP_BYPASS_EN passes raw instructions through
module dict_decompressor
  import decomp_pkg::*;
#(
  parameter int FIELD1_IDX_SIZE = DEF_FIELD1_IDX_SIZE,
  parameter int FIELD2_IDX_SIZE = DEF_FIELD2_IDX_SIZE,
  parameter int FIELD3_IDX_SIZE = DEF_FIELD3_IDX_SIZE,
  parameter int FIELD1_SIZE     = DEF_FIELD1_SIZE,
  parameter int FIELD2_SIZE     = DEF_FIELD2_SIZE,
  parameter int FIELD3_SIZE     = DEF_FIELD3_SIZE
) (
  input  logic                clk,
  input  logic                resetn,
  dict_decompressor_if.slave  bus
);

  logic          s1_valid_q, s1_valid_d;
  logic [CW-1:0] s1_cw_q, s1_cw_d;
  logic [IW-1:0] s1_addr_q, s1_addr_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_instr_q, out_instr_d;
  logic [IW-1:0] out_addr_q, out_addr_d;
`ifdef DECOMP_BYPASS_EN
  logic          s1_raw_q, s1_raw_d;
  logic [IW-1:0] s1_raw_instr_q, s1_raw_instr_d;
`endif

  logic adv2;
  logic accept;
  logic we1, we2, we3;
  logic [FIELD1_SIZE-1:0] val1;
  logic [FIELD2_SIZE-1:0] val2;
  logic [FIELD3_SIZE-1:0] val3;
  logic [IW-1:0]          lookup_instr;

  assign adv2         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || adv2;
  assign accept       = bus.in_valid && bus.in_ready;

  assign we1 = bus.dict_we && (bus.dict_sel == DSEL_F1) && idx_fits(bus.dict_idx, FIELD1_IDX_SIZE);
  assign we2 = bus.dict_we && (bus.dict_sel == DSEL_F2) && idx_fits(bus.dict_idx, FIELD2_IDX_SIZE);
  assign we3 = bus.dict_we && (bus.dict_sel == DSEL_F3) && idx_fits(bus.dict_idx, FIELD3_IDX_SIZE);

  dict_bank #(.IDX(FIELD1_IDX_SIZE), .VAL(FIELD1_SIZE)) u_f1 (
    .clk   (clk),
    .we    (we1),
    .waddr (bus.dict_idx[FIELD1_IDX_SIZE-1:0]),
    .wdata (bus.dict_wdata[FIELD1_SIZE-1:0]),
    .raddr (s1_cw_q[F1_CW_LSB +: FIELD1_IDX_SIZE]),
    .rdata (val1)
  );

  dict_bank #(.IDX(FIELD2_IDX_SIZE), .VAL(FIELD2_SIZE)) u_f2 (
    .clk   (clk),
    .we    (we2),
    .waddr (bus.dict_idx[FIELD2_IDX_SIZE-1:0]),
    .wdata (bus.dict_wdata[FIELD2_SIZE-1:0]),
    .raddr (s1_cw_q[F2_CW_LSB +: FIELD2_IDX_SIZE]),
    .rdata (val2)
  );

  dict_bank #(.IDX(FIELD3_IDX_SIZE), .VAL(FIELD3_SIZE)) u_f3 (
    .clk   (clk),
    .we    (we3),
    .waddr (bus.dict_idx[FIELD3_IDX_SIZE-1:0]),
    .wdata (bus.dict_wdata[FIELD3_SIZE-1:0]),
    .raddr (s1_cw_q[F3_CW_LSB +: FIELD3_IDX_SIZE]),
    .rdata (val3)
  );

`ifdef DECOMP_BYPASS_EN
  assign lookup_instr = s1_raw_q ? s1_raw_instr_q : {val3, val2, val1};
`else
  assign lookup_instr = {val3, val2, val1};
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cw_d     = s1_cw_q;
    s1_addr_d   = s1_addr_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
`ifdef DECOMP_BYPASS_EN
    s1_raw_d       = s1_raw_q;
    s1_raw_instr_d = s1_raw_instr_q;
`endif
    // Output payload only changes when a real word moves in, so a bubble keeps it stable.
    if (adv2) begin
      out_valid_d = s1_valid_q;
      s1_valid_d  = 1'b0;
      if (s1_valid_q) begin
        out_instr_d = lookup_instr;
        out_addr_d  = s1_addr_q;
      end
    end
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_cw_d    = bus.in_cw;
      s1_addr_d  = bus.in_addr;
`ifdef DECOMP_BYPASS_EN
      s1_raw_d       = bus.in_raw;
      s1_raw_instr_d = bus.in_raw_instr;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
`ifdef DECOMP_BYPASS_EN
      s1_raw_q       <= 1'b0;
      s1_raw_instr_q <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_addr_q   <= s1_addr_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
`ifdef DECOMP_BYPASS_EN
      s1_raw_q       <= s1_raw_d;
      s1_raw_instr_q <= s1_raw_instr_d;
`endif
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;

endmodule

// File: tb/tb_dict_decompressor.sv
// tb/tb_dict_decompressor.sv - directed self-checking bench for dict_decompressor; DECOMP_BYPASS_EN enables the raw-word sequence
module tb_dict_decompressor;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cnt = 0;

  dict_decompressor_if bus();

  dict_decompressor dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    int          cyc;
  } out_t;
  out_t got[$];

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) got.push_back('{bus.out_instr, bus.out_addr, cyc});
    if (resetn && bus.in_valid && bus.in_ready) acc_cnt++;
  end

  typedef struct {
    logic [15:0] cw;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;
  vec_t vec[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] cw, input logic [31:0] addr);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_cw    = cw;
    bus.in_addr  = addr;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck low for cw %h", cw);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

`ifdef DECOMP_BYPASS_EN
  task automatic send_raw(input logic [31:0] instr, input logic [31:0] addr);
    bus.in_raw       = 1'b1;
    bus.in_raw_instr = instr;
    send(16'h0000, addr);
    bus.in_raw       = 1'b0;
  endtask
`endif

  task automatic dict_wr(input logic [1:0] sel, input logic [7:0] idx, input logic [14:0] wdata);
    bus.dict_we    = 1'b1;
    bus.dict_sel   = sel;
    bus.dict_idx   = idx;
    bus.dict_wdata = wdata;
    @(posedge clk);
    #1;
    bus.dict_we = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (got.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_out_timeout: got %0d outputs expected %0d", got.size(), n);
    end
  endtask

  initial begin
    vec[0] = '{16'h2A02, 32'h0000_1000, 32'h5545_2D13};
    vec[1] = '{16'hFFFF, 32'h0000_1004, 32'hFFFF_FFFF};
    vec[2] = '{16'h0008, 32'h0000_1008, 32'h0000_0081};
    vec[3] = '{16'h8401, 32'h0000_100C, 32'h8020_0022};

    resetn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_cw = '0;
    bus.in_addr = '0;
    bus.out_ready = 1'b0;
    bus.dict_we = 1'b0;
    bus.dict_sel = '0;
    bus.dict_idx = '0;
    bus.dict_wdata = '0;
`ifdef DECOMP_BYPASS_EN
    bus.in_raw = 1'b0;
    bus.in_raw_instr = '0;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    dict_wr(2'd1, 8'd2, 15'h0013);
    dict_wr(2'd2, 8'h40, 15'h0A5A);
    dict_wr(2'd3, 8'd5, 15'h0155);
    dict_wr(2'd1, 8'd7, 15'h7FFF);
    dict_wr(2'd2, 8'hFF, 15'h7FFF);
    dict_wr(2'd3, 8'd31, 15'h7FFF);
    dict_wr(2'd1, 8'd0, 15'h0001);
    dict_wr(2'd2, 8'd1, 15'h0001);
    dict_wr(2'd3, 8'd0, 15'h0000);
    dict_wr(2'd1, 8'd1, 15'h0022);
    dict_wr(2'd2, 8'h80, 15'h4000);
    dict_wr(2'd3, 8'd16, 15'h0200);
    // Out-of-range indices and sel=0 must leave the table untouched.
    dict_wr(2'd1, 8'h0A, 15'h0055);
    dict_wr(2'd3, 8'h25, 15'h0000);
    dict_wr(2'd0, 8'h40, 15'h0000);

    // Test 1: single word latency.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_cw = 16'h2A02;
    bus.in_addr = 32'h100;
    @(negedge clk);
    chk("t1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_n", {31'b0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("t1_valid_n1", {31'b0, bus.out_valid}, 32'd1);
    chk("t1_instr", bus.out_instr, 32'h5545_2D13);
    chk("t1_addr", bus.out_addr, 32'h100);
    @(posedge clk);
    #1;
    got.delete();

    // Test 2: back-to-back table vectors.
    for (int i = 0; i < 4; i++) send(vec[i].cw, vec[i].addr);
    wait_out(4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b2b_instr%0d", i), got[i].instr, vec[i].exp);
      chk($sformatf("b2b_addr%0d", i), got[i].addr, vec[i].addr);
      if (i > 0) chk($sformatf("b2b_cycle%0d", i), got[i].cyc - got[0].cyc, i);
    end
    @(posedge clk);
    #1;

    // Test 3: stall under continuous in_valid.
    got.delete();
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(vec[i].cw, vec[i].addr + 32'h100);
      end
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          if (bus.out_valid) chk("stall_hold", bus.out_instr, vec[0].exp);
        end
        chk("stall_accepts", acc_cnt, 32'd2);
        chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_out(4);
    repeat (3) @(negedge clk);
    chk("stall_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall_instr%0d", i), got[i].instr, vec[i].exp);
      chk($sformatf("stall_addr%0d", i), got[i].addr, vec[i].addr + 32'h100);
    end
    @(posedge clk);
    #1;

    // Test 5: asynchronous reset mid-stream.
    got.delete();
    bus.out_ready = 1'b0;
    send(vec[1].cw, 32'h200);
    send(vec[2].cw, 32'h204);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("areset_out_instr", bus.out_instr, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("areset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("areset_valid_after", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(16'h2A02, 32'h300);
    wait_out(1);
    repeat (3) @(negedge clk);
    chk("areset_count", got.size(), 32'd1);
    chk("areset_replay", got[0].instr, 32'h5545_2D13);
    chk("areset_replay_addr", got[0].addr, 32'h300);
    @(posedge clk);
    #1;

    // Test 4: dictionary write in the same cycle as the lookup and a new accept.
    got.delete();
    send(16'h2A02, 32'h400);
    bus.dict_we = 1'b1;
    bus.dict_sel = 2'd2;
    bus.dict_idx = 8'h40;
    bus.dict_wdata = 15'h1111;
    send(16'h2A02, 32'h404);
    bus.dict_we = 1'b0;
    wait_out(2);
    chk("wr_same_cycle", got[0].instr, 32'h5545_2D13);
    chk("wr_next_lookup", got[1].instr, 32'h5548_8893);
    chk("wr_next_addr", got[1].addr, 32'h404);
    @(posedge clk);
    #1;

`ifdef DECOMP_BYPASS_EN
    // Test 6: raw instruction between two compressed words.
    got.delete();
    send(vec[2].cw, 32'h500);
    send_raw(32'hDEAD_BEEF, 32'h504);
    send(vec[3].cw, 32'h508);
    wait_out(3);
    chk("raw_first", got[0].instr, vec[2].exp);
    chk("raw_mid", got[1].instr, 32'hDEAD_BEEF);
    chk("raw_mid_addr", got[1].addr, 32'h504);
    chk("raw_last", got[2].instr, vec[3].exp);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
